// File: rtl/fifo_wr_ctrl.sv
// Write-side FIFO controller: waits for empty, settles, then writes one
// burst of DEPTH incrementing words, aborting early on full.
module fifo_wr_ctrl #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 3,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wrempty,
  input  logic              wrfull,
  output logic              wrreq,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              burst_done,
  output logic              abort,
  output logic [CNT_W-1:0]  burst_cnt
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int DLY_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [DLY_W-1:0] LAST_DLY = DLY_W'(WAIT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    WRITE
  } state_t;

  state_t            state, state_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [DLY_W-1:0]  dly, dly_n;
  logic              wrreq_n;
  logic [DATA_W-1:0] data_n;
  logic              busy_n;
  logic              done_n;
  logic              abort_n;
  logic [CNT_W-1:0]  cnt_n;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    dly_n   = dly;
    wrreq_n = 1'b0;
    data_n  = '0;
    done_n  = 1'b0;
    abort_n = 1'b0;
    cnt_n   = burst_cnt;
    unique case (state)
      IDLE: begin
        if (en && wrempty) begin
          state_n = DELAY;
          dly_n   = '0;
        end
      end
      DELAY: begin
        if (!wrempty) begin
          state_n = IDLE;
          dly_n   = '0;
        end else if (dly == LAST_DLY) begin
          state_n = WRITE;
          wrreq_n = 1'b1;
          idx_n   = '0;
          dly_n   = '0;
        end else begin
          dly_n = dly + 1'b1;
        end
      end
      WRITE: begin
        // last word wins over a coincident full flag
        if (idx == LAST_IDX) begin
          state_n = IDLE;
          idx_n   = '0;
          done_n  = 1'b1;
          cnt_n   = burst_cnt + 1'b1;
        end else if (wrfull) begin
          state_n = IDLE;
          idx_n   = '0;
          abort_n = 1'b1;
        end else begin
          wrreq_n = 1'b1;
          idx_n   = idx + 1'b1;
          data_n  = DATA_W'(idx_n);
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
        dly_n   = '0;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      dly        <= '0;
      wrreq      <= 1'b0;
      data       <= '0;
      busy       <= 1'b0;
      burst_done <= 1'b0;
      abort      <= 1'b0;
      burst_cnt  <= '0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      dly        <= dly_n;
      wrreq      <= wrreq_n;
      data       <= data_n;
      busy       <= busy_n;
      burst_done <= done_n;
      abort      <= abort_n;
      burst_cnt  <= cnt_n;
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl: timeline model checked every cycle plus
// directed burst, abort, reset and settle-drop scenarios.
module tb_fifo_wr_ctrl;

  localparam int DW = 8;
  localparam int D  = 256;
  localparam int W  = 3;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          wrempty;
  logic          wrfull;
  logic          wrreq;
  logic [DW-1:0] data;
  logic          busy;
  logic          burst_done;
  logic          abort;
  logic [CW-1:0] burst_cnt;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  fifo_wr_ctrl #(
    .DATA_W  (DW),
    .DEPTH   (D),
    .WAIT_CYC(W),
    .CNT_W   (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .wrempty   (wrempty),
    .wrfull    (wrfull),
    .wrreq     (wrreq),
    .data      (data),
    .busy      (busy),
    .burst_done(burst_done),
    .abort     (abort),
    .burst_cnt (burst_cnt)
  );

  task automatic check(input string name, input longint act,
                       input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Timeline model: a burst started at edge t0 settles for W edges,
  // then presents word i after edge t0+W+i; termination by index.
  int            ecount = 0;
  int            t0 = 0;
  bit            m_act = 0;
  bit            m_valid = 0;
  logic          e_wrreq = 0;
  logic [DW-1:0] e_data = 0;
  logic          e_busy = 0;
  logic          e_done = 0;
  logic          e_abort = 0;
  logic [CW-1:0] e_cnt = 0;

  initial begin
    logic s_rst, s_en, s_emp, s_full;
    int   t, idx;
    logic [27:0] act, exp;
    forever begin
      @(posedge clk);
      s_rst = rst; s_en = en; s_emp = wrempty; s_full = wrfull;
      ecount++;
      if (s_rst) begin
        m_act = 0; e_wrreq = 0; e_data = 0; e_busy = 0;
        e_done = 0; e_abort = 0; e_cnt = 0;
      end else if (!m_act) begin
        e_done = 0; e_abort = 0; e_wrreq = 0; e_data = 0; e_busy = 0;
        if (s_en && s_emp) begin
          m_act = 1; t0 = ecount; e_busy = 1;
        end
      end else begin
        t = ecount - t0;
        if (t <= W) begin
          if (!s_emp) begin
            m_act = 0; e_busy = 0;
          end else if (t == W) begin
            e_wrreq = 1; e_data = 0;
          end
        end else begin
          idx = t - W - 1;
          if (idx == D - 1) begin
            e_wrreq = 0; e_data = 0; e_done = 1; e_busy = 0;
            e_cnt = e_cnt + 1'b1; m_act = 0;
          end else if (s_full) begin
            e_wrreq = 0; e_data = 0; e_abort = 1; e_busy = 0; m_act = 0;
          end else begin
            e_data = DW'(idx + 1);
          end
        end
      end
      m_valid = 1;
      @(negedge clk);
      if (m_valid) begin
        act = {wrreq, data, busy, burst_done, abort, burst_cnt};
        exp = {e_wrreq, e_data, e_busy, e_done, e_abort, e_cnt};
        checks++;
        if (act === exp && !(burst_done && abort)) passed++;
        else $display("FAIL cycle %0d outputs: got %h expected %h",
                      ecount, act, exp);
      end
    end
  end

  task automatic start(output int k);
    @(negedge clk);
    en = 1'b1;
    wrempty = 1'b1;
    k = ecount + 1;
  endtask

  task automatic watch(input int k, input int full_at, input int drop_at,
                       output int first_off, output int nhi,
                       output int end_off, output int ndone,
                       output int nabort, output bit seq_ok);
    int post;
    post = -1; first_off = -1; nhi = 0; end_off = -1;
    ndone = 0; nabort = 0; seq_ok = 1;
    for (int i = 0; i < 400 && post != 0; i++) begin
      @(negedge clk);
      wrfull = 1'b0;
      if (wrreq) begin
        if (nhi == 0) begin
          first_off = ecount - k;
          wrempty = 1'b0;
        end
        if (data !== DW'(nhi)) seq_ok = 0;
        if (nhi == full_at) wrfull = 1'b1;
        if (nhi == drop_at) en = 1'b0;
        nhi++;
      end
      if (burst_done) begin ndone++; end_off = ecount - k; end
      if (abort) begin nabort++; end_off = ecount - k; end
      if (post > 0) post--;
      else if (post < 0 && (burst_done || abort)) post = 2;
    end
  endtask

  initial begin
    int k, fo, nh, eo, nd, na, n, nb;
    bit sq;
    rst = 1'b1; en = 1'b0; wrempty = 1'b0; wrfull = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_wrreq", wrreq, 0);
    check("reset_busy", busy, 0);
    check("reset_cnt", burst_cnt, 0);

    // en low with empty FIFO: nothing happens
    wrempty = 1'b1;
    nb = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || wrreq) nb++;
    end
    check("idle_no_en", nb, 0);
    wrempty = 1'b0;
    @(negedge clk);

    // full burst
    start(k);
    watch(k, -1, -1, fo, nh, eo, nd, na, sq);
    check("burst_first_wr", fo, 3);
    check("burst_words", nh, 256);
    check("burst_done_edge", eo, 259);
    check("burst_done_pulses", nd, 1);
    check("burst_no_abort", na, 0);
    check("burst_seq", sq, 1);
    check("burst_cnt1", burst_cnt, 1);

    // abort on full at data 100
    start(k);
    watch(k, 100, -1, fo, nh, eo, nd, na, sq);
    check("abort_words", nh, 101);
    check("abort_edge", eo, 104);
    check("abort_pulses", na, 1);
    check("abort_no_done", nd, 0);
    check("abort_cnt", burst_cnt, 1);

    // reset mid-burst at word 50
    start(k);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (wrreq) wrempty = 1'b0;
    end while (!(wrreq && data == 8'd50) && n < 400);
    check("rst_reach_idx50", data, 50);
    rst = 1'b1;
    @(negedge clk);
    check("rst_wrreq", wrreq, 0);
    check("rst_data", data, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", burst_cnt, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nb = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy || wrreq) nb++;
    end
    check("rst_stays_idle", nb, 0);

    // empty drops during second settle cycle
    start(k);
    @(negedge clk);
    check("delay_busy", busy, 1);
    @(negedge clk);
    wrempty = 1'b0;
    nb = 0;
    repeat (10) begin
      @(negedge clk);
      if (wrreq) nb++;
    end
    check("delay_drop_nowr", nb, 0);
    check("delay_drop_busy", busy, 0);

    // en dropped at word 10 does not stop the burst
    start(k);
    watch(k, -1, 10, fo, nh, eo, nd, na, sq);
    check("endrop_words", nh, 256);
    check("endrop_done", nd, 1);
    check("endrop_cnt", burst_cnt, 1);

    // two bursts with a drain in between, from fresh reset
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start(k);
    watch(k, -1, -1, fo, nh, eo, nd, na, sq);
    check("b2b_first_done", nd, 1);
    repeat (4) @(negedge clk);
    start(k);
    watch(k, -1, -1, fo, nh, eo, nd, na, sq);
    check("b2b_second_seq", sq, 1);
    check("b2b_second_words", nh, 256);
    check("b2b_no_abort", na, 0);
    check("b2b_cnt", burst_cnt, 2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
